// File: rtl/fifo_uart_tx_if.sv
// Signal bundle between the FIFO drain stage and its surroundings:
// FIFO read handshake, frame permission and the serial line with status.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_r_data;
  logic             rd_en;
  logic             tx;
  logic             busy;
  logic             tx_done;

  // The drain stage is the master of the FIFO read port.
  modport master (
    input  en,
    input  fifo_empty,
    input  fifo_r_data,
    output rd_en,
    output tx,
    output busy,
    output tx_done
  );

  modport slave (
    output en,
    output fifo_empty,
    output fifo_r_data,
    input  rd_en,
    input  tx,
    input  busy,
    input  tx_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: fetches one word per frame and shifts it out as a UART
// frame (start, data LSB first, optional even parity, stop).
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic          clk,
  input  logic          rst,
  fifo_uart_tx_if.master bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              tx_done_q, tx_done_d;

  logic              bit_end;
  logic [BAUD_W-1:0] baud_next;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign baud_next = bit_end ? '0 : baud_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    case (state_q)
      IDLE: begin
        if (bus.en && !bus.fifo_empty) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d  = bus.fifo_r_data;
        parity_d = ^bus.fifo_r_data;
        baud_d   = '0;
        idx_d    = '0;
        state_d  = START;
      end
      START: begin
        baud_d = baud_next;
        if (bit_end) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_next;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        baud_d = baud_next;
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        baud_d = baud_next;
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
    rd_en_d   = (state_d == FETCH);
    busy_d    = (state_d != IDLE);
    tx_done_d = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = tx_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: lane 0 runs without parity, lane 1 with even parity; both
// at four clocks per bit, each fed by a small behavioural FIFO.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] en_r = '0;
  logic [7:0] store [2][16];
  int         wr_ptr [2] = '{0, 0};
  int         rd_ptr [2] = '{0, 0};
  int         rd_cnt [2] = '{0, 0};
  logic [7:0] r_data_r [2] = '{8'h00, 8'h00};
  logic [1:0] rd_err = '0;

  logic [1:0] empty_w, rd_en_w, tx_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    fifo_uart_tx_if #(.WIDTH(8)) bus ();

    assign empty_w[gi]     = (wr_ptr[gi] == rd_ptr[gi]);
    assign bus.en          = en_r[gi];
    assign bus.fifo_empty  = empty_w[gi];
    assign bus.fifo_r_data = r_data_r[gi];
    assign rd_en_w[gi]     = bus.rd_en;
    assign tx_w[gi]        = bus.tx;
    assign busy_w[gi]      = bus.busy;
    assign done_w[gi]      = bus.tx_done;

    fifo_uart_tx #(
      .WIDTH(8),
      .CLKS_PER_BIT(4),
      .PARITY_EN(gi)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
    );
  end

  // FIFO model: data appears the cycle after rd_en is sampled.
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (rd_en_w[l]) begin
        rd_cnt[l] <= rd_cnt[l] + 1;
        if (empty_w[l]) begin
          rd_err[l] <= 1'b1;
        end else begin
          r_data_r[l] <= store[l][rd_ptr[l] % 16];
          rd_ptr[l]   <= rd_ptr[l] + 1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input int l, input logic [7:0] d);
    store[l][wr_ptr[l] % 16] = d;
    wr_ptr[l] = wr_ptr[l] + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at the falling edge inside cycle T. Samples tx mid-bit; pbit < 0
  // means no parity bit. drop_k / rst_k act right after sampling bit k.
  task automatic frame(input int l, input logic [7:0] d, input int pbit,
                       input int drop_k, input int rst_k);
    int          nb;
    int          c0;
    logic [11:0] bits;
    int          pv;
    nb   = (pbit < 0) ? 10 : 11;
    c0   = rd_cnt[l];
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (pbit >= 0) begin
      pv = pbit;
      bits[9] = pv[0];
    end
    $display("frame lane%0d data=%02h parity=%0d", l, d, pbit);
    check("idle_tx", tx_w[l], 1);
    @(negedge clk);
    check("fetch_rd_en", rd_en_w[l], 1);
    check("fetch_busy", busy_w[l], 1);
    @(negedge clk);
    check("load_rd_en", rd_en_w[l], 0);
    check("load_tx", tx_w[l], 1);
    check("load_busy", busy_w[l], 1);
    @(negedge clk);
    check("start_edge", tx_w[l], 0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      if (k > 0) repeat (4) @(negedge clk);
      check($sformatf("lane%0d_bit%0d", l, k), tx_w[l], bits[k]);
      if (k == drop_k) en_r[l] = 1'b0;
      if (k == rst_k) begin
        #2 rst = 1'b0;
        #1;
        check("rst_async_tx", tx_w[l], 1);
        check("rst_async_busy", busy_w[l], 0);
        check("rst_async_rd_en", rd_en_w[l], 0);
        check("rst_async_done", done_w[l], 0);
        return;
      end
    end
    @(negedge clk);
    check("last_stop_done", done_w[l], 0);
    check("last_stop_tx", tx_w[l], 1);
    @(negedge clk);
    check("tx_done", done_w[l], 1);
    check("done_busy", busy_w[l], 0);
    check("rd_once", rd_cnt[l] - c0, 1);
  endtask

  initial begin
    int c;

    repeat (3) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      check("reset_tx", tx_w[l], 1);
      check("reset_rd_en", rd_en_w[l], 0);
      check("reset_busy", busy_w[l], 0);
      check("reset_done", done_w[l], 0);
    end
    rst = 1'b1;
    en_r = 2'b11;
    repeat (50) @(negedge clk);
    check("empty_no_rd", rd_cnt[0] + rd_cnt[1], 0);
    check("empty_busy", busy_w, 0);
    en_r = 2'b00;

    // Single frame, no parity: tx_done at T+43.
    push(0, 8'hA5);
    en_r[0] = 1'b1;
    frame(0, 8'hA5, -1, -1, -1);
    en_r[0] = 1'b0;
    check("single_empty", empty_w[0], 1);
    repeat (5) @(negedge clk);

    // Even parity: 0x07 -> 1, 0x03 -> 0, 44-cycle frames.
    push(1, 8'h07);
    push(1, 8'h03);
    en_r[1] = 1'b1;
    frame(1, 8'h07, 1, -1, -1);
    frame(1, 8'h03, 0, -1, -1);
    en_r[1] = 1'b0;
    repeat (5) @(negedge clk);

    // Back-to-back frames with en held high.
    c = rd_cnt[0];
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    en_r[0] = 1'b1;
    frame(0, 8'h11, -1, -1, -1);
    frame(0, 8'h22, -1, -1, -1);
    frame(0, 8'h33, -1, -1, -1);
    @(negedge clk);
    check("b2b_idle_rd_en", rd_en_w[0], 0);
    check("b2b_idle_busy", busy_w[0], 0);
    check("b2b_rd_count", rd_cnt[0] - c, 3);
    check("b2b_empty", empty_w[0], 1);
    check("b2b_rd_err", rd_err, 0);
    en_r[0] = 1'b0;
    repeat (5) @(negedge clk);

    // Enable dropped during DATA bit 3: frame completes, no further fetch.
    push(0, 8'h5A);
    push(0, 8'hC3);
    en_r[0] = 1'b1;
    frame(0, 8'h5A, -1, 4, -1);
    c = rd_cnt[0];
    repeat (20) @(negedge clk);
    check("drop_no_rd", rd_cnt[0] - c, 0);
    check("drop_busy", busy_w[0], 0);
    check("drop_nonempty", empty_w[0], 0);
    en_r[0] = 1'b1;
    frame(0, 8'hC3, -1, -1, -1);
    en_r[0] = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during DATA bit 5, then a fresh frame after release.
    push(0, 8'h3C);
    push(0, 8'h96);
    en_r[0] = 1'b1;
    frame(0, 8'h3C, -1, -1, 6);
    @(negedge clk);
    check("rst_hold_tx", tx_w[0], 1);
    rst = 1'b1;
    frame(0, 8'h96, -1, -1, -1);
    en_r[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("final_rd_err", rd_err, 0);
    check("final_empty", empty_w, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the synchronous FIFO. It watches the FIFO's `empty` flag, issues single-cycle read strobes, captures each word from `r_data`, and serialises it as an asynchronous UART frame: start bit, data bits LSB first, optional even parity, then stop bit. Only one word is fetched per frame. Back-to-back frames run while the FIFO stays non-empty and `en` is high.

## Interface
- `WIDTH`, 8: data bits per frame; must equal the FIFO `WIDTH`.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `PARITY_EN`, 0: 1 inserts an even-parity bit after the data bits.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-low reset (`rst`=0 resets immediately, independent of `clk`).
- `en`  input  1  permission to start new frames; sampled only in IDLE.
- `fifo_empty`  input  1  FIFO `empty` flag.
- `fifo_r_data`  input  WIDTH  FIFO read data; valid the cycle after the FIFO samples `rd_en`=1.
- `rd_en`  output  1  registered read strobe to the FIFO; high for exactly one cycle per frame.
- `tx`  output  1  registered serial line; idles high.
- `busy`  output  1  registered; high in every state except IDLE.
- `tx_done`  output  1  registered; one-cycle pulse after the last stop-bit cycle.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx`=1, `rd_en`=0.
  - If `en`=1 and `fifo_empty`=0, go to FETCH and drive `rd_en`=1 for the FETCH cycle.
- **FETCH**
  - `rd_en` is high for this single cycle; the FIFO samples it at the end of the cycle.
  - Next state is LOAD, with `rd_en`=0.
- **LOAD**
  - At the end of the cycle, capture `fifo_r_data` into the shift register, compute parity as the XOR of all data bits, and clear the baud counter.
  - Next state is START.
- **START**
  - `tx`=0 for `CLKS_PER_BIT` cycles.
  - Next state is DATA, with bit index 0.
- **DATA**
  - `tx`=`shift[0]` for `CLKS_PER_BIT` cycles per bit.
  - At the end of each bit, shift right and increment the index.
  - After bit `WIDTH-1`: go to PARITY if `PARITY_EN`=1, otherwise to STOP.
- **PARITY**
  - `tx`=parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
- **STOP**
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - Then go to IDLE and pulse `tx_done` for one cycle (the first IDLE cycle).
- **Counter widths**
  - Baud counter is wide enough to hold `CLKS_PER_BIT-1` and wraps to 0 at the end of each bit.
  - Bit index is wide enough to hold `WIDTH-1`.
- **Flow control**
  - `en` deasserted mid-frame does not abort; the current frame completes, then the block holds in IDLE.
  - `fifo_empty` is ignored outside IDLE. The FIFO's empty flag settles before the block returns to IDLE, so a stale read is impossible.
  - No read is ever issued while `fifo_empty`=1, so the FIFO's `rd_err` is never triggered by this block.
- **Reset**
  - Assertion at any time, including mid-frame, immediately forces IDLE and sets `tx`=1, `rd_en`=0, `busy`=0, `tx_done`=0.
  - The shift register, parity bit and all counters are cleared to 0.
  - A partial frame is truncated. The word already read is lost.

## Timing
Cycle numbering: cycle T is the IDLE cycle in which `en`=1 and `fifo_empty`=0 are sampled.

| Cycle | Event |
|---|---|
| T+1 | `rd_en` high (FETCH) |
| T+2 | LOAD; `fifo_r_data` valid and captured at end of cycle |
| T+3 | `tx` falls (first START cycle); `busy` has been high since T+1 |

- Frame length on `tx` is `(2 + WIDTH + PARITY_EN) × CLKS_PER_BIT` cycles.
- `tx_done` pulses in the cycle after the last STOP cycle.
- Minimum spacing between consecutive `rd_en` pulses is `3 + (2 + WIDTH + PARITY_EN) × CLKS_PER_BIT` cycles (T+1 to the next T'+1, where T' is the `tx_done` cycle).
- Between back-to-back frames, `tx` stays high for 3 cycles (IDLE, FETCH, LOAD) beyond the stop bit.

## Test plan
- **Reset values:** hold `rst`=0 → `tx`=1, `rd_en`=0, `busy`=0, `tx_done`=0. Release with `fifo_empty`=1 for 50 cycles → no `rd_en` pulse.
- **Single frame:** `CLKS_PER_BIT`=4, `PARITY_EN`=0; FIFO holds 0xA5.
  - `rd_en` pulses once at T+1 and `tx` falls at T+3.
  - Sampling mid-bit gives 0, 1,0,1,0,0,1,0,1, 1.
  - `tx_done` pulses at T+43.
- **Parity:** `PARITY_EN`=1, FIFO holds 0x07 → parity bit 1 and frame length 44 cycles. With FIFO holding 0x03 → parity bit 0.
- **Back-to-back:** FIFO holds 0x11, 0x22, 0x33 with `en` held high.
  - Three frames are sent in order, with exactly 3 `rd_en` pulses.
  - `tx` is high for 3 extra cycles between frames.
  - The block ends in IDLE with the FIFO empty and FIFO `rd_err` never set.
- **Enable drop:** deassert `en` in the middle of DATA bit 3 → that frame completes and `tx_done` pulses. No new `rd_en` is issued while `en`=0, even though the FIFO is non-empty.
- **Reset mid-frame:** assert `rst`=0 during DATA bit 5 → `tx`=1 and `busy`=0 immediately, with no clock edge needed. After release with the FIFO non-empty, the next frame starts with a fresh `rd_en` pulse and a full start bit.
